// File: rtl/sw_axi4lite_responder.sv
// sw_axi4lite_responder: AXI4-Lite subordinate backed by a word-addressed memory.
// Terminates transactions from the sw_axi AXI4-Lite initiator; out-of-range
// accesses return SLVERR. Read and write channels run independently.
//
// Ports (AXI4-Lite names):
//   clk, rst                      clock and synchronous active-high reset
//   aw*  / w* / b*                write address, write data, write response
//   ar*  / r*                     read address, read data/response
//   awprot, arprot                accepted but ignored
//
// Optional build macro: SW_AXI_RESP_STALL_EN
//   When defined, a 16-bit LFSR inserts random ready stalls and delays the
//   rise of bvalid/rvalid. When undefined, readies and latencies are fixed.
module sw_axi4lite_responder #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            DEPTH_LOG2 = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter logic [15:0]            LFSR_SEED  = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OFFS_WIDTH = $clog2(STRB_WIDTH);
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_RESP} rd_state_t;

    // Address decode: in range when at/above the base and the word index fits.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> (OFFS_WIDTH + DEPTH_LOG2)) == '0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off[OFFS_WIDTH +: DEPTH_LOG2];
    endfunction

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    logic                   w_unused;
    assign w_unused = ^{awprot, arprot};

    // Stall sources
    logic w_stall_aw;
    logic w_stall_w;
    logic w_stall_ar;
    logic w_valid_hold;

`ifdef SW_AXI_RESP_STALL_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_stall_aw   = r_lfsr[0];
    assign w_stall_w    = r_lfsr[1];
    assign w_stall_ar   = r_lfsr[2];
    assign w_valid_hold = r_lfsr[3];
`else
    assign w_stall_aw   = 1'b0;
    assign w_stall_w    = 1'b0;
    assign w_stall_ar   = 1'b0;
    assign w_valid_hold = 1'b0;
`endif

    // ---------------- Write channel ----------------
    wr_state_t              r_wr_state;
    wr_state_t              w_wr_next;
    logic                   r_aw_held;
    logic                   r_w_held;
    logic [ADDR_WIDTH-1:0]  r_awaddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_WIDTH-1:0]  r_wstrb;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;

    logic                   w_awready;
    logic                   w_wready;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_commit;
    logic [ADDR_WIDTH-1:0]  w_wr_addr;
    logic [DATA_WIDTH-1:0]  w_wr_data;
    logic [STRB_WIDTH-1:0]  w_wr_strb;
    logic                   w_wr_ok;
    logic [DEPTH_LOG2-1:0]  w_wr_idx;

    // Readies come only from state, never from the valids.
    assign w_awready = !rst && (r_wr_state == W_IDLE) && !r_aw_held && !w_stall_aw;
    assign w_wready  = !rst && (r_wr_state == W_IDLE) && !r_w_held  && !w_stall_w;
    assign w_aw_hs   = awvalid && w_awready;
    assign w_w_hs    = wvalid  && w_wready;

    // Take each field from its holding register or straight from the bus
    // when that channel handshakes this cycle.
    assign w_wr_addr = r_aw_held ? r_awaddr : awaddr;
    assign w_wr_data = r_w_held  ? r_wdata  : wdata;
    assign w_wr_strb = r_w_held  ? r_wstrb  : wstrb;
    assign w_wr_ok   = addr_ok(w_wr_addr);
    assign w_wr_idx  = addr_idx(w_wr_addr);

    // Commit on the edge that completes the second of the AW/W handshakes.
    assign w_commit  = (r_wr_state == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    // Write next-state
    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_commit)            w_wr_next = W_RESP;
            W_RESP:  if (r_bvalid && bready)  w_wr_next = W_IDLE;
            default:                          w_wr_next = W_IDLE;
        endcase
    end

    // Write state, capture registers and B channel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            if (w_commit) begin
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                r_bvalid <= !w_valid_hold;
            end else if (r_wr_state == W_RESP) begin
                if (!r_bvalid) begin
                    r_bvalid <= !w_valid_hold;
                end else if (bready) begin
                    r_bvalid  <= 1'b0;
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                end
            end
        end
    end

    // Byte-lane memory write; contents are not reset
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_wr_ok) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (w_wr_strb[i]) begin
                    r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    // ---------------- Read channel ----------------
    rd_state_t              r_rd_state;
    rd_state_t              w_rd_next;
    logic                   r_rvalid;
    logic [1:0]             r_rresp;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   w_arready;
    logic                   w_ar_hs;
    logic                   w_rd_ok;
    logic [DEPTH_LOG2-1:0]  w_rd_idx;

    assign w_arready = !rst && (r_rd_state == R_IDLE) && !w_stall_ar;
    assign w_ar_hs   = arvalid && w_arready;
    assign w_rd_ok   = addr_ok(araddr);
    assign w_rd_idx  = addr_idx(araddr);

    // Read next-state
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs)             w_rd_next = R_RESP;
            R_RESP:  if (r_rvalid && rready)  w_rd_next = R_IDLE;
            default:                          w_rd_next = R_IDLE;
        endcase
    end

    // Read state and R channel; a same-edge write is not yet visible here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_ar_hs) begin
                r_rdata  <= w_rd_ok ? r_mem[w_rd_idx] : '0;
                r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                r_rvalid <= !w_valid_hold;
            end else if (r_rd_state == R_RESP) begin
                if (!r_rvalid) begin
                    r_rvalid <= !w_valid_hold;
                end else if (rready) begin
                    r_rvalid <= 1'b0;
                end
            end
        end
    end

    assign awready = w_awready;
    assign wready  = w_wready;
    assign arready = w_arready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign rvalid  = r_rvalid;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;

endmodule
